// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer
//   Receive side of a 4:1 word multiplexer. Each valid input word is registered
//   into one of four output lanes. The lane comes either from sel (manual mode)
//   or from an internal slot counter (auto mode). The block tracks which lanes
//   have been written in the current frame. It pulses frame_done once all four
//   lanes are written, and pulses overrun when a lane is rewritten within the
//   same frame.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   din          multiplexed input word
//   din_valid    din consumed at this edge
//   sel          target lane in manual mode
//   auto_mode    1 = slot counter picks lane, 0 = sel picks lane
//   frame_start  auto mode: force lane 0 and restart the frame
//   y0..y3       registered lane outputs
//   lane_valid   lanes written in the current frame
//   slot         next lane in auto mode
//   frame_done   one-cycle pulse when all four lanes are written
//   overrun      one-cycle pulse when a lane is rewritten within a frame
module tdm_demultiplexer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [1:0]       sel,
    input  logic             auto_mode,
    input  logic             frame_start,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       lane_valid,
    output logic [1:0]       slot,
    output logic             frame_done,
    output logic             overrun
);

    logic [WIDTH-1:0] y_q [4];
    logic [WIDTH-1:0] y_d [4];
    logic [3:0]       lane_valid_q, lane_valid_d;
    logic [1:0]       slot_q, slot_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;
    logic             mode_q, mode_d;

    logic [3:0] base_valid;
    logic [1:0] base_slot;
    logic [3:0] next_valid;
    logic [1:0] lane;
    logic       restart;

    always_comb begin
        // A mode change discards bookkeeping before this edge's word is handled.
        base_valid = (auto_mode != mode_q) ? 4'b0000 : lane_valid_q;
        base_slot  = (auto_mode != mode_q) ? 2'd0 : slot_q;

        restart = auto_mode && frame_start;
        if (!auto_mode) begin
            lane = sel;
        end else if (frame_start) begin
            lane = 2'd0;
        end else begin
            lane = base_slot;
        end

        for (int i = 0; i < 4; i++) begin
            y_d[i] = y_q[i];
        end
        lane_valid_d = base_valid;
        slot_d       = base_slot;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        mode_d       = auto_mode;
        next_valid   = base_valid;

        if (din_valid) begin
            y_d[lane] = din;
            if (restart) begin
                next_valid = 4'b0001;
            end else begin
                next_valid = base_valid | (4'b0001 << lane);
                overrun_d  = base_valid[lane];
            end
            if (next_valid == 4'b1111) begin
                frame_done_d = 1'b1;
                lane_valid_d = 4'b0000;
            end else begin
                lane_valid_d = next_valid;
            end
            if (auto_mode) begin
                slot_d = lane + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
            lane_valid_q <= 4'b0000;
            slot_q       <= 2'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            mode_q       <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= y_d[i];
            end
            lane_valid_q <= lane_valid_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            mode_q       <= mode_d;
        end
    end

    assign y0         = y_q[0];
    assign y1         = y_q[1];
    assign y2         = y_q[2];
    assign y3         = y_q[3];
    assign lane_valid = lane_valid_q;
    assign slot       = slot_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
module tb_tdm_demultiplexer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic [1:0]   sel;
    logic         auto_mode;
    logic         frame_start;
    logic [W-1:0] y0, y1, y2, y3;
    logic [3:0]   lane_valid;
    logic [1:0]   slot;
    logic         frame_done;
    logic         overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demultiplexer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sel        (sel),
        .auto_mode  (auto_mode),
        .frame_start(frame_start),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .lane_valid (lane_valid),
        .slot       (slot),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    typedef struct {
        bit       rst;   // 1 = assert reset this cycle
        bit       av;
        int       d;
        int       s;
        bit       am;
        bit       fs;
        int       ey[4];
        int       elv;
        int       eslot;
        bit       edone;
        bit       eovr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit r, input bit v, input int d, input int s, input bit am,
                       input bit fs, input int e0, input int e1, input int e2, input int e3,
                       input int lv, input int sl, input bit dn, input bit ov);
        vec_t t;
        t.rst = r; t.av = v; t.d = d; t.s = s; t.am = am; t.fs = fs;
        t.ey[0] = e0; t.ey[1] = e1; t.ey[2] = e2; t.ey[3] = e3;
        t.elv = lv; t.eslot = sl; t.edone = dn; t.eovr = ov;
        vecs.push_back(t);
    endtask

    task automatic drive(input bit r, input bit v, input int d, input int s, input bit am,
                         input bit fs);
        rst_n       = ~r;
        din_valid   = v;
        din         = W'(d);
        sel         = 2'(s);
        auto_mode   = am;
        frame_start = fs;
    endtask

    task automatic check_outputs(input string tag, input int e[4], input int lv, input int sl,
                                 input bit dn, input bit ov);
        check({tag, " y0"}, int'(y0), e[0]);
        check({tag, " y1"}, int'(y1), e[1]);
        check({tag, " y2"}, int'(y2), e[2]);
        check({tag, " y3"}, int'(y3), e[3]);
        check({tag, " lane_valid"}, int'(lane_valid), lv);
        check({tag, " slot"}, int'(slot), sl);
        check({tag, " frame_done"}, int'(frame_done), int'(dn));
        check({tag, " overrun"}, int'(overrun), int'(ov));
    endtask

    // Reference model: lanes written in this frame kept as a set of flags.
    int  m_y[4];
    bit  m_written[4];
    int  m_slot;
    bit  m_mode;
    bit  m_done;
    bit  m_ovr;

    task automatic model_step(input bit r, input bit v, input int d, input int s, input bit am,
                              input bit fs);
        int lane;
        int cnt;
        m_done = 0;
        m_ovr  = 0;
        if (r) begin
            foreach (m_y[i]) begin m_y[i] = 0; m_written[i] = 0; end
            m_slot = 0;
            m_mode = 0;
            return;
        end
        if (am != m_mode) begin
            foreach (m_written[i]) m_written[i] = 0;
            m_slot = 0;
        end
        m_mode = am;
        if (!v) return;
        if (!am)      lane = s;
        else if (fs)  lane = 0;
        else          lane = m_slot;
        if (am && fs) begin
            foreach (m_written[i]) m_written[i] = 0;
        end else begin
            m_ovr = m_written[lane];
        end
        m_written[lane] = 1;
        m_y[lane] = d;
        cnt = 0;
        foreach (m_written[i]) cnt += int'(m_written[i]);
        if (cnt == 4) begin
            m_done = 1;
            foreach (m_written[i]) m_written[i] = 0;
        end
        if (am) m_slot = (lane + 1) % 4;
    endtask

    function automatic int model_lv();
        int lv = 0;
        foreach (m_written[i]) if (m_written[i]) lv += (1 << i);
        return lv;
    endfunction

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        // rst v  d  s am fs   y0 y1 y2 y3  lv  sl dn ov
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0, 0);
        // Manual fill of all four lanes
        add(0, 1, 1, 0, 0, 0,  1, 0, 0, 0,  1,  0, 0, 0);
        add(0, 1, 2, 1, 0, 0,  1, 2, 0, 0,  3,  0, 0, 0);
        add(0, 1, 3, 2, 0, 0,  1, 2, 3, 0,  7,  0, 0, 0);
        add(0, 1, 4, 3, 0, 0,  1, 2, 3, 4,  0,  0, 1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 2, 3, 4,  0,  0, 0, 0);
        // Manual overwrite of lane 3
        add(0, 1, 5, 3, 0, 0,  1, 2, 3, 5,  8,  0, 0, 0);
        add(0, 1, 8, 3, 0, 0,  1, 2, 3, 8,  8,  0, 0, 1);
        add(0, 0, 0, 0, 0, 0,  1, 2, 3, 8,  8,  0, 0, 0);
        // Auto mode with gaps; first word also switches mode
        add(0, 1, 9, 0, 1, 0,  9, 2, 3, 8,  1,  1, 0, 0);
        add(0, 0, 0, 0, 1, 0,  9, 2, 3, 8,  1,  1, 0, 0);
        add(0, 1,12, 2, 1, 0,  9,12, 3, 8,  3,  2, 0, 0);
        add(0, 0, 0, 0, 1, 0,  9,12, 3, 8,  3,  2, 0, 0);
        add(0, 1,13, 0, 1, 0,  9,12,13, 8,  7,  3, 0, 0);
        add(0, 0, 0, 0, 1, 0,  9,12,13, 8,  7,  3, 0, 0);
        add(0, 1,14, 1, 1, 0,  9,12,13,14,  0,  0, 1, 0);
        add(0, 0, 0, 0, 1, 0,  9,12,13,14,  0,  0, 0, 0);
        // Auto restart mid-frame
        add(0, 1, 5, 0, 1, 0,  5,12,13,14,  1,  1, 0, 0);
        add(0, 1, 6, 0, 1, 0,  5, 6,13,14,  3,  2, 0, 0);
        add(0, 1, 7, 3, 1, 1,  7, 6,13,14,  1,  1, 0, 0);
        add(0, 1, 8, 0, 1, 0,  7, 8,13,14,  3,  2, 0, 0);
        add(0, 1, 1, 0, 1, 0,  7, 8, 1,14,  7,  3, 0, 0);
        add(0, 1, 2, 0, 1, 0,  7, 8, 1, 2,  0,  0, 1, 0);
        // Mode switch mid-frame
        add(0, 1, 3, 0, 0, 0,  3, 8, 1, 2,  1,  0, 0, 0);
        add(0, 1, 9, 1, 0, 0,  3, 9, 1, 2,  3,  0, 0, 0);
        add(0, 1, 3, 2, 1, 0,  3, 9, 1, 2,  1,  1, 0, 0);
        // Reset mid-frame; reset wins over a valid word
        add(0, 1, 5, 0, 1, 0,  3, 5, 1, 2,  3,  2, 0, 0);
        add(1, 1, 7, 0, 1, 0,  0, 0, 0, 0,  0,  0, 0, 0);
        add(0, 1, 4, 0, 1, 0,  4, 0, 0, 0,  1,  1, 0, 0);

        @(negedge clk);
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].av, vecs[k].d, vecs[k].s, vecs[k].am, vecs[k].fs);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", k), vecs[k].ey, vecs[k].elv, vecs[k].eslot,
                          vecs[k].edone, vecs[k].eovr);
        end

        // Randomised run against the reference model, starting from reset.
        model_step(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 600; n++) begin
            bit r, v, am, fs;
            int d, s;
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 15);
            s  = $urandom_range(0, 3);
            am = (n / 50) % 2 == 1 ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
            fs = ($urandom_range(0, 9) == 0);
            drive(r, v, d, s, am, fs);
            model_step(r, v, d, s, am, fs);
            @(posedge clk);
            #1;
            check_outputs($sformatf("rand%0d", n), m_y, model_lv(), m_slot, m_done, m_ovr);
            n_checks++;
            if (frame_done && overrun) begin
                n_fail++;
                $display("FAIL rand%0d pulses: frame_done=%0b overrun=%0b both set", n,
                         frame_done, overrun);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
